// File: rtl/rms_window_feeder.sv
// rms_window_feeder: squares a signed sample stream, sums 2**LOG_N squares
// per window and emits the rounded mean-of-squares as a one-cycle
// radicand/start pair for a downstream pipelined square-root core.
module rms_window_feeder #(
    parameter int DATA_BITS  = 8,
    parameter int LOG_N      = 2,
    parameter int INPUT_BITS = 16,
    localparam int FILL_W    = (LOG_N == 0) ? 1 : LOG_N
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_BITS-1:0]  in_data,
    input  logic                  clear,
    output logic                  start,
    output logic [INPUT_BITS-1:0] radicand,
    output logic [FILL_W-1:0]     fill
);

    localparam int SQ_W  = 2 * DATA_BITS;
    localparam int ACC_W = SQ_W + LOG_N;
    localparam int N     = 1 << LOG_N;

    // Half of the window length gives round-half-up; zero for single-sample windows.
    localparam logic [ACC_W-1:0]  ROUND     = ACC_W'(N >> 1);
    localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(N - 1);

    logic signed [SQ_W-1:0] din_ext;
    logic signed [SQ_W-1:0] prod;
    logic [SQ_W-1:0]        sq;
    logic                   sq_v;
    logic                   sq_last;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       sum_last;
    logic [SQ_W-1:0]        mean;

    // Signed square and the rounded window total when the last square arrives.
    always_comb begin
        din_ext  = SQ_W'($signed(in_data));
        prod     = din_ext * din_ext;
        sum_last = acc + ACC_W'(sq) + ROUND;
        mean     = sum_last[ACC_W-1:LOG_N];
    end

    // Stage 1: register the square, tag the window's last sample, advance fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            sq      <= '0;
            sq_v    <= 1'b0;
            sq_last <= 1'b0;
            fill    <= '0;
        end else if (clear) begin
            sq_v    <= 1'b0;
            sq_last <= 1'b0;
            fill    <= '0;
        end else if (in_valid) begin
            sq      <= prod;
            sq_v    <= 1'b1;
            sq_last <= (fill == LAST_FILL);
            fill    <= (fill == LAST_FILL) ? '0 : fill + 1'b1;
        end else begin
            sq_v    <= 1'b0;
        end
    end

    // Stage 2: accumulate squares; on the last one emit the mean and restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            start    <= 1'b0;
            radicand <= '0;
        end else if (clear) begin
            acc      <= '0;
            start    <= 1'b0;
        end else begin
            start <= 1'b0;
            if (sq_v) begin
                if (sq_last) begin
                    radicand <= INPUT_BITS'(mean);
                    acc      <= '0;
                    start    <= 1'b1;
                end else begin
                    acc <= acc + ACC_W'(sq);
                end
            end
        end
    end

endmodule
